// File: rtl/demux6to1_buf.sv
// demux6to1_buf: steers one flit stream into six 2-deep per-channel FIFOs by select code,
// so a stalled output only blocks flits addressed to it.
module demux6to1_buf #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [2:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [6*WIDTH-1:0] out_data,
  output logic [5:0]         out_valid,
  input  logic [5:0]         out_ready
);
  logic [2:0]       dst;
  logic [1:0]       cnt  [6];
  logic [WIDTH-1:0] head [6];
  logic [WIDTH-1:0] tail [6];
  // sel[1] is ignored for the upper two channels
  assign dst      = in_sel[2] ? {2'b10, in_sel[0]} : {1'b0, in_sel[1:0]};
  assign in_ready = (cnt[dst] != 2'd2) || out_ready[dst];
  for (genvar i = 0; i < 6; i++) begin : g_ch
    logic       push;
    logic       pop;
    logic [1:0] nxt;
    assign push                        = in_valid && in_ready && (dst == 3'(i));
    assign pop                         = out_valid[i] && out_ready[i];
    assign out_valid[i]                = cnt[i] != 2'd0;
    assign out_data[i*WIDTH +: WIDTH]  = head[i];
    assign nxt                         = cnt[i] + {1'b0, push} - {1'b0, pop};
    // new flit lands in head when it ends up the only entry, otherwise behind it
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt[i]  <= 2'd0;
        head[i] <= '0;
        tail[i] <= '0;
      end else begin
        cnt[i] <= nxt;
        if (pop && cnt[i] == 2'd2) head[i] <= tail[i];
        else if (push && nxt == 2'd1) head[i] <= in_data;
        if (push && nxt == 2'd2) tail[i] <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_demux6to1_buf.sv
// tb_demux6to1_buf: directed vectors with hand-computed expectations for demux6to1_buf.
module tb_demux6to1_buf;
  localparam int W = 16;
  logic           clk = 0;
  logic           reset = 0;
  logic [W-1:0]   in_data = '0;
  logic [2:0]     in_sel = '0;
  logic           in_valid = 0;
  logic           in_ready;
  logic [6*W-1:0] out_data;
  logic [5:0]     out_valid;
  logic [5:0]     out_ready = '0;
  int checks = 0;
  int passes = 0;

  demux6to1_buf #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6*W-1:0] got, input logic [6*W-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ch(input int i);
    return out_data[i*W +: W];
  endfunction

  task automatic push(input logic [2:0] sel, input logic [W-1:0] d);
    in_sel = sel;
    in_data = d;
    in_valid = 1;
    #1 chk("push_ready", in_ready, 1);
    tick();
    in_valid = 0;
  endtask

  int exp_ch [8] = '{0, 1, 2, 3, 4, 5, 4, 5};

  initial begin
    // asynchronous reset between edges
    #7 reset = 1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    for (int s = 0; s < 8; s++) begin
      in_sel = 3'(s);
      #1 chk($sformatf("rst_ready_sel%0d", s), in_ready, 1);
    end
    tick();
    tick();
    reset = 0;
    tick();
    chk("idle_valid", out_valid, 0);

    // decode sweep, back-to-back with all outputs draining
    out_ready = 6'h3F;
    for (int k = 0; k < 8; k++) begin
      in_sel = 3'(k);
      in_data = 16'hA000 + 16'(k);
      in_valid = 1;
      #1 chk($sformatf("sweep_ready%0d", k), in_ready, 1);
      tick();
      chk($sformatf("sweep_valid%0d", k), out_valid, 6'b1 << exp_ch[k]);
      chk($sformatf("sweep_data%0d", k), ch(exp_ch[k]), 16'hA000 + 16'(k));
    end
    in_valid = 0;
    tick();
    chk("sweep_drained", out_valid, 0);

    // fill channel c while it is stalled
    out_ready = 6'b111011;
    push(3'b010, 16'h0001);
    push(3'b010, 16'h0002);
    chk("fill_valid", out_valid, 6'b000100);
    chk("fill_head", ch(2), 16'h0001);

    // head-of-line isolation: e still accepts while c is full
    push(3'b100, 16'h00BB);
    chk("hol_valid", out_valid, 6'b010100);
    chk("hol_e", ch(4), 16'h00BB);
    chk("hol_c", ch(2), 16'h0001);

    // third flit to full, stalled c is refused
    in_sel = 3'b010;
    in_data = 16'h0003;
    in_valid = 1;
    #1 chk("full_ready", in_ready, 0);
    tick();
    chk("full_hold_head", ch(2), 16'h0001);
    chk("full_hold_valid", out_valid, 6'b000100);
    chk("full_ready2", in_ready, 0);
    out_ready = 6'h3F;
    #1 chk("drain_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("order1", ch(2), 16'h0002);
    tick();
    chk("order2", ch(2), 16'h0003);
    chk("order2_valid", out_valid, 6'b000100);
    tick();
    chk("order_empty", out_valid, 0);

    // simultaneous push and pop keeps occupancy at one
    out_ready = 6'b110111;
    push(3'b011, 16'h5555);
    chk("pp_pre", ch(3), 16'h5555);
    out_ready = 6'h3F;
    push(3'b011, 16'h1234);
    chk("pp_head", ch(3), 16'h1234);
    chk("pp_valid", out_valid, 6'b001000);
    tick();
    chk("pp_one_entry", out_valid, 0);

    // reset mid-operation with a and f full
    out_ready = 6'b0;
    push(3'b000, 16'h0A01);
    push(3'b000, 16'h0A02);
    push(3'b101, 16'h0F01);
    push(3'b101, 16'h0F02);
    chk("pre_rst_valid", out_valid, 6'b100001);
    in_sel = 3'b000;
    in_data = 16'hDEAD;
    in_valid = 1;
    #2 reset = 1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    tick();
    tick();
    chk("midrst_held", out_valid, 0);
    in_valid = 0;
    reset = 0;
    out_ready = 6'h3F;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst%0d", k), out_valid, 0);
    end
    push(3'b000, 16'h7777);
    chk("fresh_valid", out_valid, 6'b000001);
    chk("fresh_data", ch(0), 16'h7777);
    tick();
    chk("fresh_gone", out_valid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/demux6to1_buf.md
Name: demux6to1_buf

Overview:
- Inverse of the six-way select: one flit stream is steered to one of six output channels by a 3-bit select code.
- Each output channel has a 2-entry FIFO with valid/ready handshake, so a stalled downstream port only blocks traffic addressed to it.
- Sits on the router output side, between the switch-allocation stage and the six per-port output links.

Parameters:
- WIDTH, 16, flit width in bits (minimum 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  incoming flit.
- in_sel  input  3  destination select code, sampled together with in_data.
- in_valid  input  1  in_data/in_sel are valid this cycle.
- in_ready  output  1  combinational; flit is accepted when in_valid && in_ready at a clk edge.
- out_data  output  6*WIDTH  packed heads of the six FIFOs; channel a at [WIDTH-1:0] through channel f at [6*WIDTH-1:5*WIDTH].
- out_valid  output  6  per-channel head valid; bit 0 = a ... bit 5 = f.
- out_ready  input  6  per-channel downstream ready.

Behaviour:
- Select decode, identical to the six-way mux encoding:
  - 000 -> a (0), 001 -> b (1), 010 -> c (2), 011 -> d (3).
  - 1x0 -> e (4), 1x1 -> f (5); sel[1] is ignored when sel[2]=1.
- Per-channel state:
  - 2-entry FIFO holding head and tail registers.
  - 2-bit occupancy cnt[i], range 0..2.
  - out_valid[i] = (cnt[i] != 0).
  - out_data slice i = head register; its value is don't-care when out_valid[i]=0.
- in_ready:
  - 1 when cnt[dec(in_sel)] < 2, or when cnt[dec(in_sel)] == 2 and out_ready[dec(in_sel)] == 1 (full but draining this cycle).
  - Combinational from in_sel, cnt, out_ready; it does not depend on in_valid.
- Push: in_valid && in_ready writes in_data into FIFO dec(in_sel) only. No other channel changes because of the push.
- Pop on channel i: out_valid[i] && out_ready[i]. Head advances; out_ready[i] while out_valid[i]=0 has no effect.
- Per-channel cycle update:
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop together: cnt unchanged; the new flit enters behind the remaining entry.
  - neither: hold.
- Latency: a flit accepted at edge N appears on out_data/out_valid after edge N, with no combinational input-to-output path. Minimum 1 cycle from acceptance to visibility.
- Write into an empty channel goes directly to the head register.
- Ordering: FIFO order per channel. No ordering guarantee across channels.
- Throughput: one push per cycle in total. Pops on all six channels may occur in the same cycle.
- Upstream must hold in_data/in_sel stable while in_valid && !in_ready. The block does not check this.
- Reset (asynchronous, active-high, any time including mid-transfer):
  - all cnt = 0, out_valid = 6'b0, head/tail registers = 0, so out_data = 0.
  - Any flit presented during reset is not accepted.
  - Normal operation resumes on the first clk edge after reset deasserts.
- No flits are ever dropped or duplicated. Overflow is impossible by construction of in_ready.

Test Plan:
- Reset then idle:
  - reset=1 asynchronously mid-cycle -> out_valid=000000, out_data=0, in_ready=1 for every in_sel, immediately.
- Decode sweep, all out_ready=1:
  - Send 0xA000..0xA007 with in_sel=000..111 back-to-back.
  - Each flit appears one cycle later on channel a, b, c, d, e, f, e, f respectively.
  - sel 110 -> e and 111 -> f.
- Fill and stall:
  - out_ready[2]=0; send 0x0001, 0x0002, 0x0003 with in_sel=010.
  - First two accepted, cnt=2, in_ready=0 on the third.
  - Raise out_ready[2] -> third is accepted in that same cycle; c outputs 0x0001, 0x0002, 0x0003 in order.
- Head-of-line isolation:
  - Channel c full and stalled; send 0x00BB with in_sel=100.
  - in_ready=1, flit appears on e next cycle; channel c unchanged.
- Simultaneous push/pop:
  - Channel d holds 1 entry; push 0x1234 to d with out_ready[3]=1.
  - cnt stays 1, head becomes 0x1234 after the edge.
- Reset mid-operation:
  - Channels a and f hold 2 entries each; assert reset.
  - All out_valid=0; no old flit ever reappears after reset release.
